xosera_bus_arbiter: RTL and testbench

//  Shares the single xosera_main host bus (cs_n/rd_nwr/reg_num/bytesel/data) between two requesters:

---
 rtl/xosera_bus_arbiter_if.sv | 23 ++
 rtl/xosera_bus_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_xosera_bus_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xosera_bus_arbiter_if.sv
// Requester-side bundle for the xosera host bus arbiter: two ports packed side by side.
// No latency of its own; pure wiring between requesters and the arbiter.
// Backpressure: each req bit is held until the matching ack bit pulses.
interface xosera_bus_arbiter_if;
  logic [1:0]  req_i;      // per-port request, held until ack
  logic [1:0]  wr_i;       // per-port 1=write, 0=read
  logic [7:0]  reg_num_i;  // {port1[3:0], port0[3:0]}
  logic [1:0]  bytesel_i;  // per-port 0=even byte, 1=odd byte
  logic [15:0] wdata_i;    // {port1[7:0], port0[7:0]}
  logic [1:0]  ack_o;      // one-cycle completion pulse per port
  logic [15:0] rdata_o;    // {port1, port0} read data
  logic [1:0]  grant_o;    // one-hot owner of in-flight access

  modport master (
    output req_i, wr_i, reg_num_i, bytesel_i, wdata_i,
    input  ack_o, rdata_o, grant_o
  );

  modport slave (
    input  req_i, wr_i, reg_num_i, bytesel_i, wdata_i,
    output ack_o, rdata_o, grant_o
  );
endinterface

// File: rtl/xosera_bus_arbiter.sv
// Two-port arbiter sequencing byte accesses onto the xosera_main host bus, with even/odd word lock.
// Latency: req seen in IDLE -> ack CS_CYCLES+RD_LATENCY+2 cycles later; one access per CS_CYCLES+RD_LATENCY+3.
// Backpressure: a losing or locked-out port keeps req high and simply gets no ack until it is served.
// Optional macro XOSERA_ARB_TIMEOUT_EN: drops a word lock after LOCK_TIMEOUT idle cycles without owner request.
module xosera_bus_arbiter #(
  parameter int CS_CYCLES    = 2,
  parameter int RD_LATENCY   = 2,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset_n_i,
  xosera_bus_arbiter_if.slave        host,
  output logic                       bus_cs_n_o,
  output logic                       bus_rd_nwr_o,
  output logic [3:0]                 bus_reg_num_o,
  output logic                       bus_bytesel_o,
  output logic [7:0]                 bus_data_o,
  input  logic [7:0]                 bus_data_i
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_RECOVER, S_ACK} state_t;

  localparam int PMAX = (CS_CYCLES > RD_LATENCY) ? CS_CYCLES : RD_LATENCY;
  localparam int PW   = (PMAX > 1) ? $clog2(PMAX) : 1;

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          win_q, last_q, lock_q, owner_q;
  logic          rd_nwr_q, bsel_q;
  logic [3:0]    reg_q;
  logic [7:0]    data_q;
  logic [15:0]   rdata_q;
  logic [1:0]    elig;
  logic          win_d, start, capture, done;

  // Eligibility (only the owner while a word is open) and round-robin winner pick
  always_comb begin
    elig = host.req_i;
    if (lock_q) elig = owner_q ? (host.req_i & 2'b10) : (host.req_i & 2'b01);
    if (elig == 2'b11) win_d = ~last_q;
    else               win_d = elig[1];
  end

  // Access sequencer: next state, phase countdown and one-shot strobes
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    start   = 1'b0;
    capture = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|elig) begin
          start   = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        phase_d = PW'(CS_CYCLES - 1);
      end
      S_STROBE: begin
        if (phase_q == '0) begin
          state_d = S_RECOVER;
          phase_d = PW'(RD_LATENCY - 1);
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      S_RECOVER: begin
        if (phase_q == '0) begin
          capture = rd_nwr_q;
          state_d = S_ACK;
        end else begin
          phase_d = phase_q - PW'(1);
        end
      end
      S_ACK: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; async reset drops cs_n straight away since cs_n decodes the state
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Latch the winner's fields; they stay stable on the bus until the next access
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      win_q    <= 1'b0;
      last_q   <= 1'b1;
      rd_nwr_q <= 1'b1;
      reg_q    <= '0;
      bsel_q   <= 1'b0;
      data_q   <= '0;
    end else if (start) begin
      win_q    <= win_d;
      last_q   <= win_d;
      rd_nwr_q <= ~host.wr_i[win_d];
      reg_q    <= win_d ? host.reg_num_i[7:4] : host.reg_num_i[3:0];
      bsel_q   <= host.bytesel_i[win_d];
      data_q   <= win_d ? host.wdata_i[15:8] : host.wdata_i[7:0];
    end
  end

  // Read data capture on the last recover cycle into the winner's byte lane
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rdata_q <= '0;
    end else if (capture) begin
      if (win_q) rdata_q[15:8] <= bus_data_i;
      else       rdata_q[7:0]  <= bus_data_i;
    end
  end

`ifdef XOSERA_ARB_TIMEOUT_EN
  localparam int TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  logic [TW-1:0] idle_cnt_q;
  logic          owner_req;
  assign owner_req = host.req_i[owner_q];

  // Word lock: even byte opens it, owner's odd byte closes it, stale locks expire in IDLE
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lock_q     <= 1'b0;
      owner_q    <= 1'b0;
      idle_cnt_q <= '0;
    end else begin
      if (done) begin
        if (!bsel_q) begin
          lock_q  <= 1'b1;
          owner_q <= win_q;
        end else if (lock_q && owner_q == win_q) begin
          lock_q <= 1'b0;
        end
      end
      if (!lock_q || (start && win_d == owner_q)) begin
        idle_cnt_q <= '0;
      end else if (state_q == S_IDLE && !owner_req) begin
        if (idle_cnt_q == TW'(LOCK_TIMEOUT - 1)) begin
          lock_q     <= 1'b0;
          idle_cnt_q <= '0;
        end else begin
          idle_cnt_q <= idle_cnt_q + TW'(1);
        end
      end
    end
  end
`else
  // Timeout disabled: the parameter is kept only for a uniform interface
  logic unused_timeout;
  assign unused_timeout = (LOCK_TIMEOUT != 0);

  // Word lock: even byte opens it, owner's odd byte closes it
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lock_q  <= 1'b0;
      owner_q <= 1'b0;
    end else if (done) begin
      if (!bsel_q) begin
        lock_q  <= 1'b1;
        owner_q <= win_q;
      end else if (lock_q && owner_q == win_q) begin
        lock_q <= 1'b0;
      end
    end
  end
`endif

  assign bus_cs_n_o    = (state_q != S_STROBE);
  assign bus_rd_nwr_o  = rd_nwr_q;
  assign bus_reg_num_o = reg_q;
  assign bus_bytesel_o = bsel_q;
  assign bus_data_o    = data_q;

  assign host.ack_o    = (state_q == S_ACK) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
  assign host.grant_o  = (state_q == S_IDLE) ? 2'b00 : (win_q ? 2'b10 : 2'b01);
  assign host.rdata_o  = rdata_q;

endmodule

// File: tb/tb_xosera_bus_arbiter.sv
// Bench for xosera_bus_arbiter: directed scenarios plus randomized traffic against a transaction model.
// Timing: inputs driven and outputs sampled 1ns after each rising clock edge.
// Builds with or without XOSERA_ARB_TIMEOUT_EN; the lock timeout scenario adapts to the macro.
module tb_xosera_bus_arbiter;
  localparam int CS    = 2;
  localparam int RL    = 2;
  localparam int TO    = 8;
  localparam int T_CAP = CS + RL + 1;
  localparam int T_ACK = CS + RL + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cs_n, rd_nwr, bsel;
  logic [3:0] regn;
  logic [7:0] bdo, bdi;

  int passed = 0;
  int total  = 0;

  xosera_bus_arbiter_if h();

  xosera_bus_arbiter #(.CS_CYCLES(CS), .RD_LATENCY(RL), .LOCK_TIMEOUT(TO)) dut (
    .clk(clk), .reset_n_i(rst_n), .host(h),
    .bus_cs_n_o(cs_n), .bus_rd_nwr_o(rd_nwr), .bus_reg_num_o(regn),
    .bus_bytesel_o(bsel), .bus_data_o(bdo), .bus_data_i(bdi)
  );

  always #5 clk = ~clk;

  // Transaction-level reference: phase m_t counts cycles since the access left IDLE
  int         m_t, m_win, m_last, m_owner, m_cnt;
  bit         m_lock, m_wr, m_bsel;
  logic [3:0] m_reg;
  logic [7:0] m_data;
  logic [7:0] m_rd [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    h.req_i = 2'b00; h.wr_i = 2'b00; h.reg_num_i = 8'h00;
    h.bytesel_i = 2'b00; h.wdata_i = 16'h0000;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    bdi = 8'h00;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_ack(input int p, input int limit, output int n);
    n = -1;
    for (int i = 0; i < limit; i++) begin
      if (h.ack_o[p]) begin n = i; break; end
      tick();
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_win = 0; m_last = 1; m_owner = 0; m_cnt = 0;
    m_lock = 0; m_wr = 0; m_bsel = 0; m_reg = 0; m_data = 0;
    m_rd[0] = 8'h00; m_rd[1] = 8'h00;
  endtask

  // Advance the reference across the coming clock edge using the inputs now applied
  task automatic model_edge();
    int w;
    bit e0, e1;
    if (m_t == 0) begin
      e0 = h.req_i[0] && (!m_lock || m_owner == 0);
      e1 = h.req_i[1] && (!m_lock || m_owner == 1);
      w = -1;
      if (e0 && e1) w = 1 - m_last;
      else if (e0)  w = 0;
      else if (e1)  w = 1;
`ifdef XOSERA_ARB_TIMEOUT_EN
      if (!m_lock) m_cnt = 0;
      else if (w == m_owner) m_cnt = 0;
      else if (!h.req_i[m_owner]) begin
        m_cnt++;
        if (m_cnt == TO) begin m_lock = 0; m_cnt = 0; end
      end
`endif
      if (w >= 0) begin
        m_t = 1; m_win = w; m_last = w;
        m_wr   = h.wr_i[w];
        m_reg  = h.reg_num_i[w*4 +: 4];
        m_bsel = h.bytesel_i[w];
        m_data = h.wdata_i[w*8 +: 8];
      end
    end else if (m_t == T_ACK) begin
      if (!m_bsel) begin m_lock = 1; m_owner = m_win; end
      else if (m_lock && m_owner == m_win) m_lock = 0;
      m_t = 0;
    end else begin
      if (m_t == T_CAP && !m_wr) m_rd[m_win] = bdi;
      m_t++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    h.req_i = 2'b11; h.wr_i = 2'b01; h.reg_num_i = 8'h5A; h.bytesel_i = 2'b01; h.wdata_i = 16'hBEEF;
    bdi = 8'hC3;
    tick(); tick();
    total++; if (cs_n !== 1'b1)       $display("FAIL reset_cs_n got=%b exp=1", cs_n); else passed++;
    total++; if (rd_nwr !== 1'b1)     $display("FAIL reset_rd_nwr got=%b exp=1", rd_nwr); else passed++;
    total++; if (regn !== 4'h0)       $display("FAIL reset_reg_num got=%h exp=0", regn); else passed++;
    total++; if (bsel !== 1'b0)       $display("FAIL reset_bytesel got=%b exp=0", bsel); else passed++;
    total++; if (bdo !== 8'h00)       $display("FAIL reset_data got=%h exp=00", bdo); else passed++;
    total++; if (h.ack_o !== 2'b00)   $display("FAIL reset_ack got=%b exp=00", h.ack_o); else passed++;
    total++; if (h.rdata_o !== 16'h0) $display("FAIL reset_rdata got=%h exp=0000", h.rdata_o); else passed++;
    total++; if (h.grant_o !== 2'b00) $display("FAIL reset_grant got=%b exp=00", h.grant_o); else passed++;
    clear_inputs();
    rst_n = 1'b1;
    tick();
    total++; if (h.grant_o !== 2'b00) $display("FAIL reset_idle_grant got=%b exp=00", h.grant_o); else passed++;
  endtask

  task automatic test_write_timing();
    do_reset();
    h.req_i = 2'b01; h.wr_i = 2'b01; h.reg_num_i = 8'h03; h.bytesel_i = 2'b00; h.wdata_i = 16'h00A5;
    for (int c = 1; c <= 7; c++) begin
      tick();
      total++;
      if (cs_n !== ((c == 2 || c == 3) ? 1'b0 : 1'b1))
        $display("FAIL wr_cs_n cycle=%0d got=%b", c, cs_n); else passed++;
      total++;
      if (h.ack_o !== ((c == 6) ? 2'b01 : 2'b00))
        $display("FAIL wr_ack cycle=%0d got=%b", c, h.ack_o); else passed++;
      total++;
      if (h.grant_o !== ((c <= 6) ? 2'b01 : 2'b00))
        $display("FAIL wr_grant cycle=%0d got=%b", c, h.grant_o); else passed++;
      if (c == 2) begin
        total++; if (rd_nwr !== 1'b0) $display("FAIL wr_rd_nwr got=%b exp=0", rd_nwr); else passed++;
        total++; if (regn !== 4'h3)   $display("FAIL wr_reg_num got=%h exp=3", regn); else passed++;
        total++; if (bdo !== 8'hA5)   $display("FAIL wr_data got=%h exp=a5", bdo); else passed++;
        total++; if (bsel !== 1'b0)   $display("FAIL wr_bytesel got=%b exp=0", bsel); else passed++;
      end
      if (c == 6) h.req_i = 2'b00;
    end
  endtask

  task automatic test_read();
    int n;
    do_reset();
    h.req_i = 2'b01; h.wr_i = 2'b00; h.reg_num_i = 8'h01; h.bytesel_i = 2'b01; bdi = 8'h5A;
    wait_ack(0, 20, n);
    total++; if (n < 0) $display("FAIL rd_p0_ack got=none exp=ack"); else passed++;
    h.req_i = 2'b00;
    tick();
    h.req_i = 2'b10; h.reg_num_i = 8'h50; h.bytesel_i = 2'b10; bdi = 8'hFF;
    for (int c = 1; c <= 6; c++) begin
      tick();
      bdi = (c == 5) ? 8'h3C : 8'hFF;
      if (c == 2) begin
        total++; if (rd_nwr !== 1'b1) $display("FAIL rd_rd_nwr got=%b exp=1", rd_nwr); else passed++;
        total++; if (regn !== 4'h5)   $display("FAIL rd_reg_num got=%h exp=5", regn); else passed++;
        total++; if (bsel !== 1'b1)   $display("FAIL rd_bytesel got=%b exp=1", bsel); else passed++;
      end
    end
    total++; if (h.ack_o !== 2'b10)         $display("FAIL rd_ack got=%b exp=10", h.ack_o); else passed++;
    total++; if (h.rdata_o[15:8] !== 8'h3C) $display("FAIL rd_rdata_hi got=%h exp=3c", h.rdata_o[15:8]); else passed++;
    total++; if (h.rdata_o[7:0] !== 8'h5A)  $display("FAIL rd_rdata_lo got=%h exp=5a", h.rdata_o[7:0]); else passed++;
    h.req_i = 2'b00;
    tick();
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [4];
    logic [1:0] exp;
    int k = 0;
    do_reset();
    for (int j = 0; j < 4; j++) seq[j] = 2'b00;
    h.req_i = 2'b11; h.wr_i = 2'b11; h.bytesel_i = 2'b11; h.reg_num_i = 8'h72; h.wdata_i = 16'h1234;
    for (int i = 0; i < 80 && k < 4; i++) begin
      if (h.ack_o != 2'b00) begin seq[k] = h.ack_o; k++; end
      tick();
    end
    h.req_i = 2'b00;
    total++; if (k != 4) $display("FAIL rr_count got=%0d exp=4", k); else passed++;
    for (int j = 0; j < 4; j++) begin
      exp = (j % 2 == 0) ? 2'b01 : 2'b10;
      total++; if (seq[j] !== exp) $display("FAIL rr_order idx=%0d got=%b exp=%b", j, seq[j], exp); else passed++;
    end
    tick();
  endtask

  task automatic test_lock();
    logic [1:0] seq [2];
    int n;
    int k = 0;
    do_reset();
    seq[0] = 2'b00; seq[1] = 2'b00;
    h.req_i = 2'b01; h.wr_i = 2'b11; h.bytesel_i = 2'b00; h.wdata_i = 16'h2211;
    wait_ack(0, 20, n);
    total++; if (n < 0) $display("FAIL lock_even_ack got=none exp=ack"); else passed++;
    h.req_i = 2'b10; h.bytesel_i = 2'b11;
    tick(); tick();
    h.req_i = 2'b11;
    for (int i = 0; i < 60 && k < 2; i++) begin
      if (h.ack_o != 2'b00) begin
        seq[k] = h.ack_o; k++;
        h.req_i = h.req_i & ~h.ack_o;
      end
      tick();
    end
    total++; if (seq[0] !== 2'b01) $display("FAIL lock_first got=%b exp=01", seq[0]); else passed++;
    total++; if (seq[1] !== 2'b10) $display("FAIL lock_second got=%b exp=10", seq[1]); else passed++;
    h.req_i = 2'b00;
  endtask

  task automatic test_lock_timeout();
    int n;
    do_reset();
    h.req_i = 2'b01; h.wr_i = 2'b01; h.bytesel_i = 2'b00;
    wait_ack(0, 20, n);
    total++; if (n < 0) $display("FAIL to_even_ack got=none exp=ack"); else passed++;
    h.req_i = 2'b10; h.bytesel_i = 2'b10; h.wr_i = 2'b00;
`ifdef XOSERA_ARB_TIMEOUT_EN
    tick();
    wait_ack(1, TO + 40, n);
    total++; if (n < 0) $display("FAIL to_p1_ack got=none exp=ack"); else passed++;
    total++; if (n >= 0 && n < TO) $display("FAIL to_p1_early got=%0d exp>=%0d", n, TO); else passed++;
`else
    begin
      bit seen = 0;
      for (int i = 0; i < 60; i++) begin
        if (h.ack_o[1]) seen = 1;
        tick();
      end
      total++; if (seen) $display("FAIL to_locked_out got=ack exp=none"); else passed++;
      h.req_i = 2'b11; h.bytesel_i = 2'b11;
      wait_ack(0, 20, n);
      total++; if (n < 0) $display("FAIL to_p0_odd got=none exp=ack"); else passed++;
      h.req_i = 2'b10;
      tick();
      wait_ack(1, 20, n);
      total++; if (n < 0) $display("FAIL to_p1_after got=none exp=ack"); else passed++;
    end
`endif
    h.req_i = 2'b00;
    tick();
  endtask

  task automatic test_req_drop();
    do_reset();
    h.req_i = 2'b01; h.wr_i = 2'b01; h.bytesel_i = 2'b01;
    tick();
    h.req_i = 2'b00;
    for (int c = 1; c <= 7; c++) begin
      total++;
      if (h.ack_o !== ((c == 6) ? 2'b01 : 2'b00))
        $display("FAIL drop_ack cycle=%0d got=%b", c, h.ack_o); else passed++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    h.req_i = 2'b01; h.wr_i = 2'b01; h.bytesel_i = 2'b01; h.reg_num_i = 8'h09;
    tick(); tick();
    total++; if (cs_n !== 1'b0) $display("FAIL mid_strobe got=%b exp=0", cs_n); else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (cs_n !== 1'b1)       $display("FAIL mid_cs_n got=%b exp=1", cs_n); else passed++;
    total++; if (h.grant_o !== 2'b00) $display("FAIL mid_grant got=%b exp=00", h.grant_o); else passed++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (h.ack_o !== 2'b00) $display("FAIL mid_no_ack cyc=%0d got=%b", i, h.ack_o); else passed++;
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      total++;
      if (cs_n !== ((c == 2 || c == 3) ? 1'b0 : 1'b1))
        $display("FAIL mid_restart_cs cycle=%0d got=%b", c, cs_n); else passed++;
    end
    total++; if (h.ack_o !== 2'b01) $display("FAIL mid_restart_ack got=%b exp=01", h.ack_o); else passed++;
    h.req_i = 2'b00;
    tick();
  endtask

  task automatic test_random();
    logic [1:0]  ea, eg;
    logic        ecs;
    logic [15:0] erd;
    bit          le [2];
    int          nfail = 0;
    do_reset();
    model_reset();
    le[0] = 0; le[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      ea = 2'b00; if (m_t == T_ACK) ea[m_win] = 1'b1;
      eg = 2'b00; if (m_t != 0)     eg[m_win] = 1'b1;
      ecs = !(m_t >= 2 && m_t <= CS + 1);
      erd = {m_rd[1], m_rd[0]};
      total++; if (h.ack_o !== ea)   begin nfail++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", i, h.ack_o, ea); end else passed++;
      total++; if (h.grant_o !== eg) begin nfail++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", i, h.grant_o, eg); end else passed++;
      total++; if (cs_n !== ecs)     begin nfail++; $display("FAIL rnd_cs_n cyc=%0d got=%b exp=%b", i, cs_n, ecs); end else passed++;
      total++; if (h.rdata_o !== erd) begin nfail++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", i, h.rdata_o, erd); end else passed++;
      if (!ecs) begin
        total++;
        if (rd_nwr !== !m_wr || regn !== m_reg || bsel !== m_bsel || bdo !== m_data) begin
          nfail++;
          $display("FAIL rnd_fields cyc=%0d got=%b/%h/%b/%h exp=%b/%h/%b/%h",
                   i, rd_nwr, regn, bsel, bdo, !m_wr, m_reg, m_bsel, m_data);
        end else passed++;
      end
      if (nfail > 20) break;
      for (int p = 0; p < 2; p++) begin
        if (m_t == T_ACK && m_win == p) begin
          h.req_i[p] = 1'b0;
          le[p] = !h.bytesel_i[p];
        end else if (!h.req_i[p] && $urandom_range(0, 2) == 0) begin
          h.wr_i[p]             = 1'($urandom_range(0, 1));
          h.reg_num_i[p*4 +: 4] = 4'($urandom_range(0, 15));
          h.bytesel_i[p]        = le[p] ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
          h.wdata_i[p*8 +: 8]   = 8'($urandom_range(0, 255));
          h.req_i[p]            = 1'b1;
        end
      end
      bdi = 8'($urandom);
      model_edge();
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    bdi = 8'h00;
    #1;
    test_reset();
    test_write_timing();
    test_read();
    test_round_robin();
    test_lock();
    test_lock_timeout();
    test_req_drop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
